// File: rtl/edge_pkg.sv
// Shared definitions for the gradient (Sobel) stage: FSM state encoding,
// saturation limit and quantised edge-direction codes.
package edge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    PROCESS = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } grad_state_t;

  localparam int SAT_MAX = 255;

  localparam logic [1:0] DIR_HORIZ  = 2'd0;
  localparam logic [1:0] DIR_VERT   = 2'd1;
  localparam logic [1:0] DIR_DIAG45 = 2'd2;
  localparam logic [1:0] DIR_OTHER  = 2'd3;

endpackage

// File: rtl/sobel_unit.sv
// Combinational 3x3 Sobel operator with |Gx|+|Gy| magnitude saturated to
// SAT_MAX. Optional feature macro GRADIENT_DIR_EN adds a quantised direction.
// Pixel p[r][c] (r = top/mid/bot, c = left..right) sits at pix[8*(3*r+c) +: 8].
module sobel_unit
  import edge_pkg::*;
(
  input  logic [71:0] pix,
  output logic [7:0]  mag
`ifdef GRADIENT_DIR_EN
  ,
  output logic [1:0]  dir
`endif
);

  logic [10:0]        p [3][3];
  logic signed [10:0] gx;
  logic signed [10:0] gy;
  logic [9:0]         ax;
  logic [9:0]         ay;
  logic [11:0]        sum;

  // Gradients fit in 11-bit signed (|G| <= 1020), so modular 11-bit
  // arithmetic on zero-extended pixels yields the exact two's complement value.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        p[r][c] = {3'b000, pix[8*(3*r+c) +: 8]};
      end
    end
    gx  = $signed((p[0][2] + (p[1][2] << 1) + p[2][2]) -
                  (p[0][0] + (p[1][0] << 1) + p[2][0]));
    gy  = $signed((p[2][0] + (p[2][1] << 1) + p[2][2]) -
                  (p[0][0] + (p[0][1] << 1) + p[0][2]));
    ax  = gx[10] ? 10'(-gx) : gx[9:0];
    ay  = gy[10] ? 10'(-gy) : gy[9:0];
    sum = {2'b00, ax} + {2'b00, ay};
    mag = (sum > 12'(SAT_MAX)) ? 8'(SAT_MAX) : sum[7:0];
  end

`ifdef GRADIENT_DIR_EN
  // Direction bins are tested in priority order; a zero gradient is horizontal.
  always_comb begin
    if ({ay, 1'b0} <= {1'b0, ax}) begin
      dir = DIR_HORIZ;
    end else if ({ax, 1'b0} <= {1'b0, ay}) begin
      dir = DIR_VERT;
    end else if (gx[10] == gy[10]) begin
      dir = DIR_DIAG45;
    end else begin
      dir = DIR_OTHER;
    end
  end
`endif

endmodule

// File: rtl/gradient_controller.sv
// Gradient stage: caches the last three blurred rows and produces Sobel
// magnitudes for the interior columns of the middle row, one column per cycle
// through a two-stage pipeline. Optional feature macro GRADIENT_DIR_EN adds
// the grad_dir output (quantised edge direction per column).
//
// Handshake: blur_final is a one-cycle valid with no ready. It is accepted
// only in IDLE or DONE; a pulse in LOAD/PROCESS/DRAIN is dropped and sets the
// sticky overrun flag. grad_final is a one-cycle valid for grad_out.
// Packing: pixel i of blur_row is blur_row[8*i +: 8] (i = 0 leftmost);
// grad_out[8*j +: 8] is the magnitude for column j+1.
module gradient_controller
  import edge_pkg::*;
#(
  parameter int NUM_PIX = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      blur_final,
  input  logic [8*NUM_PIX-1:0]      blur_row,
  input  logic                      first_row,
  output logic [8*(NUM_PIX-2)-1:0]  grad_out,
  output logic                      grad_final,
  output logic                      overrun,
`ifdef GRADIENT_DIR_EN
  output logic [2*(NUM_PIX-2)-1:0]  grad_dir,
`endif
  output logic [2:0]                dbg_state
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_PIX - 3);

  grad_state_t                 state_q, state_d;
  logic [3:0]                  idx_q, idx_d;
  logic [8*NUM_PIX-1:0]        row_q, row_d;
  logic                        first_q, first_d;
  logic [8*NUM_PIX-1:0]        top_q, top_d;
  logic [8*NUM_PIX-1:0]        mid_q, mid_d;
  logic [8*NUM_PIX-1:0]        bot_q, bot_d;
  logic [8*(NUM_PIX-2)-1:0]    grad_q, grad_d;
  logic [7:0]                  mag_q, mag_d;
  logic                        overrun_q, overrun_d;
  logic [71:0]                 win;
  logic [7:0]                  mag_c;
`ifdef GRADIENT_DIR_EN
  logic [1:0]                  dir_c;
  logic [1:0]                  dir_q, dir_d;
  logic [2*(NUM_PIX-2)-1:0]    gdir_q, gdir_d;
`endif

  // Gather the 3x3 window whose left column is the current issue index.
  always_comb begin
    win = '0;
    for (int c = 0; c < 3; c++) begin
      win[8*c +: 8]     = top_q[8*(int'(idx_q)+c) +: 8];
      win[8*(3+c) +: 8] = mid_q[8*(int'(idx_q)+c) +: 8];
      win[8*(6+c) +: 8] = bot_q[8*(int'(idx_q)+c) +: 8];
    end
  end

  sobel_unit u_sobel (
    .pix (win),
    .mag (mag_c)
`ifdef GRADIENT_DIR_EN
    ,
    .dir (dir_c)
`endif
  );

  // Next-state logic: FSM sequencing, row capture, cache shift and result writes.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    row_d     = row_q;
    first_d   = first_q;
    top_d     = top_q;
    mid_d     = mid_q;
    bot_d     = bot_q;
    grad_d    = grad_q;
    mag_d     = mag_q;
    overrun_d = overrun_q;
`ifdef GRADIENT_DIR_EN
    dir_d     = dir_q;
    gdir_d    = gdir_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (blur_final) begin
          row_d   = blur_row;
          first_d = first_row;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // A first row has no predecessors, so it fills the whole window.
        if (first_q) begin
          top_d = row_q;
          mid_d = row_q;
          bot_d = row_q;
        end else begin
          top_d = mid_q;
          mid_d = bot_q;
          bot_d = row_q;
        end
        idx_d   = '0;
        state_d = PROCESS;
      end
      PROCESS: begin
        // Stage 1 captures this column; stage 2 retires the previous one.
        mag_d = mag_c;
`ifdef GRADIENT_DIR_EN
        dir_d = dir_c;
`endif
        if (idx_q != 4'd0) begin
          grad_d[8*(int'(idx_q)-1) +: 8] = mag_q;
`ifdef GRADIENT_DIR_EN
          gdir_d[2*(int'(idx_q)-1) +: 2] = dir_q;
`endif
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      DRAIN: begin
        grad_d[8*int'(LAST_IDX) +: 8] = mag_q;
`ifdef GRADIENT_DIR_EN
        gdir_d[2*int'(LAST_IDX) +: 2] = dir_q;
`endif
        state_d = DONE;
      end
      DONE: begin
        if (blur_final) begin
          row_d   = blur_row;
          first_d = first_row;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (blur_final && (state_q == LOAD || state_q == PROCESS || state_q == DRAIN)) begin
      overrun_d = 1'b1;
    end
  end

  // State register; reset clears everything including the cache and results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      row_q     <= '0;
      first_q   <= 1'b0;
      top_q     <= '0;
      mid_q     <= '0;
      bot_q     <= '0;
      grad_q    <= '0;
      mag_q     <= '0;
      overrun_q <= 1'b0;
`ifdef GRADIENT_DIR_EN
      dir_q     <= '0;
      gdir_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      row_q     <= row_d;
      first_q   <= first_d;
      top_q     <= top_d;
      mid_q     <= mid_d;
      bot_q     <= bot_d;
      grad_q    <= grad_d;
      mag_q     <= mag_d;
      overrun_q <= overrun_d;
`ifdef GRADIENT_DIR_EN
      dir_q     <= dir_d;
      gdir_q    <= gdir_d;
`endif
    end
  end

  assign grad_out   = grad_q;
  assign grad_final = (state_q == DONE);
  assign overrun    = overrun_q;
  assign dbg_state  = state_q;
`ifdef GRADIENT_DIR_EN
  assign grad_dir   = gdir_q;
`endif

endmodule

// File: doc/gradient_controller.md
GRADIENT_CONTROLLER -- requirements
Module: gradient_controller

Interface
REQ-001 SHALL have parameter NUM_PIX, default 16, meaning the pixels per blurred row received from the blur stage; supported value is 16 only.
REQ-002 SHALL have clk  input  1  clock; all logic is rising-edge.
REQ-003 SHALL have rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have blur_final  input  1  one-cycle pulse; blur_row is valid in this cycle.
REQ-005 SHALL have blur_row  input  8 x NUM_PIX  blurred row from the blur stage, index 0 is leftmost.
REQ-006 SHALL have first_row  input  1  high with blur_final when the row is the image's first row.
REQ-007 SHALL have grad_out  output  8 x (NUM_PIX-2)  gradient magnitudes for columns 1..NUM_PIX-2 of the middle cached row.
REQ-008 SHALL have grad_final  output  1  one-cycle pulse; grad_out is complete and stable.
REQ-009 SHALL have overrun  output  1  sticky flag; a blur_final arrived while busy.

Function
REQ-010 SHALL keep a 3-row cache (top, mid, bot) of NUM_PIX x 8 bits.
REQ-011 SHALL use FSM states IDLE, LOAD, PROCESS, DRAIN, DONE.
- IDLE->LOAD on blur_final.
- LOAD->PROCESS always.
- PROCESS->DRAIN after column index 13 is issued.
- DRAIN->DONE always.
- DONE->LOAD on blur_final, else IDLE.
REQ-012 SHALL, on accepted blur_final, register blur_row and shift the cache in LOAD: top<=mid, mid<=bot, bot<=new row.
- If first_row was high, all three rows SHALL be loaded with the new row instead.
REQ-013 SHALL, in PROCESS, issue one column per cycle via a 4-bit index 0..13; the centre column is index+1.
REQ-014 SHALL compute the Sobel response on the 3x3 window (r=top/mid/bot, c=index..index+2):
- Gx = (p[0][2]+2p[1][2]+p[2][2]) - (p[0][0]+2p[1][0]+p[2][0])
- Gy = (p[2][0]+2p[2][1]+p[2][2]) - (p[0][0]+2p[0][1]+p[0][2])
- Gx and Gy are 11-bit signed, with no overflow.
REQ-015 SHALL form mag = |Gx|+|Gy| (12 bits unsigned) and saturate it to 255 when mag > 255.
REQ-016 SHALL pipeline the datapath in two stages: Gx/Gy registered in the issue cycle, grad_out[index] written one cycle later; DRAIN writes column 13.
REQ-017 SHALL set timing relative to blur_final sampled in cycle T:
- LOAD at T+1
- issues at T+2..T+15
- DRAIN at T+16
- grad_final high for exactly cycle T+17 (state DONE)
REQ-018 SHALL hold grad_out unchanged outside PROCESS/DRAIN writes.
REQ-019 SHALL ignore blur_final in LOAD, PROCESS or DRAIN, leave the cache untouched, and set overrun to 1 until reset.
REQ-020 SHALL accept blur_final in DONE; grad_final is still 1 in that cycle, and LOAD follows.

Reset
REQ-021 SHALL, with rst high at a clock edge, force state IDLE, index 0, cache and grad_out all zero, grad_final 0, overrun 0, and the pipeline registers 0.
REQ-022 SHALL, on rst mid-operation, abort with no grad_final pulse; blur_final coincident with rst is ignored.

Configuration
REQ-023 SHALL support macro GRADIENT_DIR_EN.
- When defined: add output grad_dir 2 x (NUM_PIX-2), the quantised direction per column, written alongside grad_out.
  - 0: |Gy|*2 <= |Gx| (horizontal)
  - 1: |Gx|*2 <= |Gy| (vertical)
  - 2: Gx,Gy same sign (diagonal 45)
  - 3: otherwise
  - Reset value 0.
- When undefined: port absent, logic absent, all else identical.

Structure
REQ-024 SHALL place the FSM state typedef (grad_state_t), SAT_MAX=255 and the direction encodings in shared package edge_pkg.
REQ-025 SHALL implement the Sobel arithmetic and saturation as sub-module sobel_unit: 9 pixels in; magnitude, plus direction when GRADIENT_DIR_EN, out; combinational.

Verification
REQ-026 SHALL cover: flat row 100s with first_row=1 -> grad_out all 0, grad_final at T+17.
REQ-027 SHALL cover: first_row=1 row with columns 0..7=0 and 8..15=200 -> grad_out[6] and [7]=255 (|Gx|=800 saturated), all others 0.
REQ-028 SHALL cover: rows top=0s, mid=0s, bot=10s, shifted in over three passes -> last pass grad_out all 40 (Gy=40).
REQ-029 SHALL cover: blur_final again at T+5 -> overrun=1, grad_out equals single-row result, next blur_final in DONE accepted with no gap.
REQ-030 SHALL cover: rst asserted at T+8 -> all outputs 0 next cycle, no grad_final.
REQ-031 SHALL cover, under GRADIENT_DIR_EN: the vertical-edge case of REQ-027 -> grad_dir[6]=0, and the REQ-028 case -> grad_dir=1.
